// File: rtl/bus_xfer_arb.sv
// Two-requester round-robin arbiter that sequences register-to-register moves
// over a shared 8-bit bus: DRIVE enables the source, LATCH also loads the destination.
module bus_xfer_arb #(
  parameter int NREG = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req0,
  input  logic [SELW-1:0] src0,
  input  logic [SELW-1:0] dst0,
  output logic            ack0,
  input  logic            req1,
  input  logic [SELW-1:0] src1,
  input  logic [SELW-1:0] dst1,
  output logic            ack1,
  output logic [NREG-1:0] oa,
  output logic [NREG-1:0] wa,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, REJECT} state_t;

  state_t          state_q;
  logic            prio_q;
  logic            win_q;
  logic [SELW-1:0] src_q;
  logic [SELW-1:0] dst_q;
  logic [NREG-1:0] oa_q;
  logic [NREG-1:0] wa_q;
  logic            ack0_q;
  logic            ack1_q;
  logic            err_q;
  logic            busy_q;

  logic            win_d;
  logic [SELW-1:0] src_d;
  logic [SELW-1:0] dst_d;

  function automatic logic [NREG-1:0] onehot(input logic [SELW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // A lone requester wins outright; on contention the pointer decides.
  always_comb begin
    win_d = (req0 && req1) ? prio_q : req1;
    src_d = win_d ? src1 : src0;
    dst_d = win_d ? dst1 : dst0;
  end

  // NOTE: every register in this block uses non-blocking assignment so all
  // state updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      win_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      oa_q    <= '0;
      wa_q    <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            win_q  <= win_d;
            prio_q <= ~win_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            busy_q <= 1'b1;
            if (src_d == dst_d) begin
              state_q <= REJECT;
              ack0_q  <= ~win_d;
              ack1_q  <= win_d;
              err_q   <= 1'b1;
            end else begin
              state_q <= DRIVE;
              oa_q    <= onehot(src_d);
            end
          end
        end
        DRIVE: begin
          state_q <= LATCH;
          wa_q    <= onehot(dst_q);
          ack0_q  <= ~win_q;
          ack1_q  <= win_q;
        end
        LATCH: begin
          state_q <= IDLE;
          oa_q    <= '0;
          wa_q    <= '0;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        REJECT: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          oa_q    <= '0;
          wa_q    <= '0;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oa   = oa_q;
  assign wa   = wa_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bus_xfer_arb.sv
// Bench for bus_xfer_arb: directed scenarios plus random traffic, checked against
// a transaction-level model that expands each grant into its expected output cycles.
module tb_bus_xfer_arb;

  logic       clk = 1'b0;
  logic       clr;
  logic       req0, req1;
  logic [1:0] src0, dst0, src1, dst1;
  logic       ack0, ack1, busy, err;
  logic [3:0] oa, wa;

  int tests_run    = 0;
  int tests_failed = 0;
  bit mon_en       = 1'b0;

  typedef struct packed {
    logic [3:0] oa;
    logic [3:0] wa;
    logic       ack0;
    logic       ack1;
    logic       err;
    logic       busy;
  } obs_t;

  // Model state: pending expected outputs for the remaining cycles of a grant.
  obs_t exp_q[$];
  obs_t exp_now;
  bit   m_prio;

  bus_xfer_arb #(.NREG(4), .SELW(2)) dut (
    .clk (clk),  .clr (clr),
    .req0(req0), .src0(src0), .dst0(dst0), .ack0(ack0),
    .req1(req1), .src1(src1), .dst1(dst1), .ack1(ack1),
    .oa  (oa),   .wa  (wa),   .busy(busy), .err (err)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    obs_t o;
    o.oa = oa; o.wa = wa; o.ack0 = ack0; o.ack1 = ack1; o.err = err; o.busy = busy;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("oa=%b wa=%b ack0=%b ack1=%b err=%b busy=%b",
                     o.oa, o.wa, o.ack0, o.ack1, o.err, o.busy);
  endfunction

  // Advance the model on the current inputs, then clock the DUT and settle.
  task automatic tick();
    obs_t       a, b;
    bit         w;
    logic [1:0] s, d;
    logic [3:0] oh_s, oh_d;
    if (clr) begin
      exp_q.delete();
      m_prio  = 1'b0;
      exp_now = '0;
    end else if (exp_q.size() > 0) begin
      exp_now = exp_q.pop_front();
    end else if (req0 || req1) begin
      w      = (req0 && req1) ? m_prio : req1;
      m_prio = !w;
      s      = w ? src1 : src0;
      d      = w ? dst1 : dst0;
      oh_s   = 4'b0001 << s;
      oh_d   = 4'b0001 << d;
      a      = '0;
      b      = '0;
      a.busy = 1'b1;
      if (s == d) begin
        a.ack0 = !w; a.ack1 = w; a.err = 1'b1;
        exp_now = a;
        exp_q.push_back('0);
      end else begin
        a.oa = oh_s;
        b.oa = oh_s; b.wa = oh_d; b.ack0 = !w; b.ack1 = w; b.busy = 1'b1;
        exp_now = a;
        exp_q.push_back(b);
        exp_q.push_back('0);
      end
    end else begin
      exp_now = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; req0 = 1'b0; req1 = 1'b0;
    src0 = '0; dst0 = '0; src1 = '0; dst1 = '0;
    tick();
    clr = 1'b0;
  endtask

  // Structural invariants sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      tests_run++;
      if (!$onehot0(oa) || !$onehot0(wa) || ((oa & wa) != 4'b0000) || (ack0 && ack1)) begin
        tests_failed++;
        $display("FAIL invariant t=%0t: oa=%b wa=%b ack0=%b ack1=%b", $time, oa, wa, ack0, ack1);
      end
    end
  end

  task automatic test_reset();
    obs_t zero = '0;
    do_reset();
    mon_en = 1'b1;
    tests_run++;
    if (dut_obs() !== zero) begin
      tests_failed++;
      $display("FAIL reset_state: got %s want %s", fmt(dut_obs()), fmt(zero));
    end
  endtask

  task automatic test_single();
    obs_t tab[3];
    tab[0] = '0; tab[0].oa = 4'b0010; tab[0].busy = 1'b1;
    tab[1] = '0; tab[1].oa = 4'b0010; tab[1].wa = 4'b0100; tab[1].ack0 = 1'b1; tab[1].busy = 1'b1;
    tab[2] = '0;
    do_reset();
    req0 = 1'b1; src0 = 2'd1; dst0 = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      req0 = 1'b0; src0 = 2'd3; dst0 = 2'd0;
      tests_run++;
      if (dut_obs() !== tab[i]) begin
        tests_failed++;
        $display("FAIL single_c%0d: got %s want %s", i + 1, fmt(dut_obs()), fmt(tab[i]));
      end
    end
  endtask

  task automatic test_contention();
    obs_t tab[6];
    tab[0] = '0; tab[0].oa = 4'b0001; tab[0].busy = 1'b1;
    tab[1] = '0; tab[1].oa = 4'b0001; tab[1].wa = 4'b0010; tab[1].ack0 = 1'b1; tab[1].busy = 1'b1;
    tab[2] = '0;
    tab[3] = '0; tab[3].oa = 4'b0100; tab[3].busy = 1'b1;
    tab[4] = '0; tab[4].oa = 4'b0100; tab[4].wa = 4'b1000; tab[4].ack1 = 1'b1; tab[4].busy = 1'b1;
    tab[5] = '0;
    do_reset();
    req0 = 1'b1; src0 = 2'd0; dst0 = 2'd1;
    req1 = 1'b1; src1 = 2'd2; dst1 = 2'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) req0 = 1'b0;
      if (i == 3) req1 = 1'b0;
      tests_run++;
      if (dut_obs() !== tab[i] || dut_obs() !== exp_now) begin
        tests_failed++;
        $display("FAIL contention_c%0d: got %s want %s", i + 1, fmt(dut_obs()), fmt(tab[i]));
      end
    end
  endtask

  task automatic test_reject();
    obs_t rej;
    obs_t zero = '0;
    rej = '0; rej.ack1 = 1'b1; rej.err = 1'b1; rej.busy = 1'b1;
    do_reset();
    req1 = 1'b1; src1 = 2'd3; dst1 = 2'd3;
    tick();
    req1 = 1'b0;
    tests_run++;
    if (dut_obs() !== rej) begin
      tests_failed++;
      $display("FAIL reject_pulse: got %s want %s", fmt(dut_obs()), fmt(rej));
    end
    tick();
    tests_run++;
    if (dut_obs() !== zero) begin
      tests_failed++;
      $display("FAIL reject_idle: got %s want %s", fmt(dut_obs()), fmt(zero));
    end
    // Pointer must be back at requester 0 after the rejected grant to requester 1.
    req0 = 1'b1; src0 = 2'd0; dst0 = 2'd1;
    req1 = 1'b1; src1 = 2'd2; dst1 = 2'd3;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tests_run++;
    if (oa !== 4'b0001 || oa !== exp_now.oa) begin
      tests_failed++;
      $display("FAIL reject_prio: got oa=%b want oa=0001", oa);
    end
    tick();
    tick();
  endtask

  task automatic test_clr_abort();
    obs_t zero = '0;
    obs_t lat;
    lat = '0; lat.oa = 4'b0010; lat.wa = 4'b0100; lat.ack0 = 1'b1; lat.busy = 1'b1;
    do_reset();
    req0 = 1'b1; src0 = 2'd1; dst0 = 2'd2;
    tick();
    req0 = 1'b0;
    clr  = 1'b1;
    tick();
    clr  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (dut_obs() !== zero) begin
        tests_failed++;
        $display("FAIL clr_abort_c%0d: got %s want %s", i, fmt(dut_obs()), fmt(zero));
      end
      tick();
    end
    req0 = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tests_run++;
    if (dut_obs() !== zero) begin
      tests_failed++;
      $display("FAIL clr_over_req: got %s want %s", fmt(dut_obs()), fmt(zero));
    end
    tick();
    req0 = 1'b0;
    tick();
    tests_run++;
    if (dut_obs() !== lat) begin
      tests_failed++;
      $display("FAIL clr_recover: got %s want %s", fmt(dut_obs()), fmt(lat));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int winners[$];
    int cycles[$];
    do_reset();
    req0 = 1'b1; src0 = 2'd0; dst0 = 2'd3;
    req1 = 1'b1; src1 = 2'd1; dst1 = 2'd2;
    for (int c = 1; c <= 14; c++) begin
      tick();
      tests_run++;
      if (dut_obs() !== exp_now) begin
        tests_failed++;
        $display("FAIL b2b_c%0d: got %s want %s", c, fmt(dut_obs()), fmt(exp_now));
      end
      if (ack0 === 1'b1) begin winners.push_back(0); cycles.push_back(c); end
      if (ack1 === 1'b1) begin winners.push_back(1); cycles.push_back(c); end
    end
    req0 = 1'b0; req1 = 1'b0;
    tests_run++;
    if (winners.size() < 4) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d acks want at least 4", winners.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (winners[k] != (k % 2)) begin
          tests_failed++;
          $display("FAIL b2b_order_%0d: got requester %0d want %0d", k, winners[k], k % 2);
        end
        if (k > 0) begin
          tests_run++;
          if (cycles[k] - cycles[k-1] != 3) begin
            tests_failed++;
            $display("FAIL b2b_spacing_%0d: got %0d want 3", k, cycles[k] - cycles[k-1]);
          end
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clr  = ($urandom_range(0, 31) == 0);
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      src0 = 2'($urandom_range(0, 3));
      dst0 = 2'($urandom_range(0, 3));
      src1 = 2'($urandom_range(0, 3));
      dst1 = 2'($urandom_range(0, 3));
      tick();
      tests_run++;
      if (dut_obs() !== exp_now) begin
        tests_failed++;
        $display("FAIL random_c%0d: got %s want %s", c, fmt(dut_obs()), fmt(exp_now));
      end
    end
    clr = 1'b0; req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    clr = 1'b1; req0 = 1'b0; req1 = 1'b0;
    src0 = '0; dst0 = '0; src1 = '0; dst1 = '0;
    exp_now = '0; m_prio = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_reject();
    test_clr_abort();
    test_back_to_back();
    test_random();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
